// File: rtl/cc1200_spi_responder.sv
// CC1200-style SPI responder: 2**ADDR_W x 8 register file, single/burst access, status during header.
// Optional abort statistics (abort_cnt, err_flag) are built when CC1200_SPI_RESP_ERR_EN is defined.
module cc1200_spi_responder #(
  parameter int         ADDR_W      = 6,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RST_VAL     = 8'h00
) (
  input  logic              ILA_clk,
  input  logic              rstn,
  input  logic              SCLK,
  input  logic              CS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_oe,
  input  logic [7:0]        status,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [7:0]        dbg_data
`ifdef CC1200_SPI_RESP_ERR_EN
  ,
  output logic [15:0]       abort_cnt,
  output logic              err_flag
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic                   sclk_prev_reg;
  logic                   cs_prev_reg;

  logic [6:0]        shift_in_reg;
  logic [7:0]        shift_out_reg;
  logic [2:0]        bit_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              rw_reg;
  logic              burst_reg;
  logic              miso_reg;
  logic              miso_oe_reg;
  logic              wr_valid_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [7:0]        wr_data_reg;

  logic [7:0] regfile [DEPTH];

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic byte_done;
  logic [7:0]        byte_in;
  logic [ADDR_W-1:0] hdr_addr;
  logic [ADDR_W-1:0] addr_inc;

  logic start_txn, abort_txn, bit_en, miso_upd, hdr_done, data_done, do_write;

  // Input synchronisers; CS_n resets to its inactive level so reset release is quiet.
  always_ff @(posedge ILA_clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_reg <= '0;
      cs_sync_reg   <= '1;
      mosi_sync_reg <= '0;
      sclk_prev_reg <= 1'b0;
      cs_prev_reg   <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], SCLK};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], CS_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], MOSI};
      sclk_prev_reg <= sclk_s;
      cs_prev_reg   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_s & sclk_prev_reg;
  assign cs_fall   = ~cs_s & cs_prev_reg;
  assign cs_rise   = cs_s & ~cs_prev_reg;

  assign byte_in   = {shift_in_reg, mosi_s};
  assign byte_done = sclk_rise & (bit_cnt_reg == 3'd7);
  assign hdr_addr  = ADDR_W'(byte_in[5:0]);
  assign addr_inc  = addr_reg + ADDR_W'(1);

  always_ff @(posedge ILA_clk or negedge rstn) begin
    if (!rstn) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cs_fall) state_next = ST_HEADER;
      end
      ST_HEADER: begin
        if (cs_rise)        state_next = ST_IDLE;
        else if (byte_done) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (cs_rise)                      state_next = ST_IDLE;
        else if (byte_done && !burst_reg) state_next = ST_HEADER;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // CS_n deassertion overrides any SCLK edge seen in the same cycle.
  always_comb begin
    start_txn = 1'b0;
    abort_txn = 1'b0;
    bit_en    = 1'b0;
    miso_upd  = 1'b0;
    hdr_done  = 1'b0;
    data_done = 1'b0;
    do_write  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        start_txn = cs_fall;
      end
      ST_HEADER, ST_DATA: begin
        abort_txn = cs_rise;
        bit_en    = sclk_rise & ~cs_rise;
        miso_upd  = sclk_fall & ~cs_rise;
        hdr_done  = (state_reg == ST_HEADER) & byte_done & ~cs_rise;
        data_done = (state_reg == ST_DATA) & byte_done & ~cs_rise;
        do_write  = (state_reg == ST_DATA) & byte_done & ~cs_rise & ~rw_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ILA_clk or negedge rstn) begin
    if (!rstn) begin
      shift_in_reg  <= '0;
      shift_out_reg <= '0;
      bit_cnt_reg   <= '0;
      addr_reg      <= '0;
      rw_reg        <= 1'b0;
      burst_reg     <= 1'b0;
      miso_reg      <= 1'b0;
      miso_oe_reg   <= 1'b0;
    end else begin
      if (start_txn) begin
        shift_out_reg <= status;
        miso_reg      <= status[7];
        miso_oe_reg   <= 1'b1;
        bit_cnt_reg   <= '0;
      end
      if (abort_txn) begin
        miso_reg    <= 1'b0;
        miso_oe_reg <= 1'b0;
        bit_cnt_reg <= '0;
      end
      if (bit_en) begin
        shift_in_reg <= byte_in[6:0];
        bit_cnt_reg  <= bit_cnt_reg + 3'd1;
      end
      // Bit index is 7-bit_cnt, so a byte loaded on the 8th rise starts at its MSB.
      if (miso_upd) miso_reg <= shift_out_reg[~bit_cnt_reg];
      if (hdr_done) begin
        rw_reg    <= byte_in[7];
        burst_reg <= byte_in[6];
        addr_reg  <= hdr_addr;
        if (byte_in[7]) shift_out_reg <= regfile[hdr_addr];
      end
      if (data_done) begin
        if (burst_reg) begin
          addr_reg <= addr_inc;
          if (rw_reg) shift_out_reg <= regfile[addr_inc];
        end else begin
          shift_out_reg <= status;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_rf
      always_ff @(posedge ILA_clk or negedge rstn) begin
        if (!rstn)                                        regfile[gi] <= RST_VAL;
        else if (do_write && (addr_reg == ADDR_W'(gi)))  regfile[gi] <= byte_in;
      end
    end
  endgenerate

  always_ff @(posedge ILA_clk or negedge rstn) begin
    if (!rstn) begin
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      wr_valid_reg <= do_write;
      if (do_write) begin
        wr_addr_reg <= addr_reg;
        wr_data_reg <= byte_in;
      end
    end
  end

  assign MISO     = miso_reg;
  assign MISO_oe  = miso_oe_reg;
  assign wr_valid = wr_valid_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign dbg_data = regfile[dbg_addr];

`ifdef CC1200_SPI_RESP_ERR_EN
  logic        data_seen_reg;
  logic [15:0] abort_cnt_reg;
  logic        err_flag_reg;
  logic        abort_evt;

  // A header followed by no complete data byte is an abort even with bit_cnt at 0.
  assign abort_evt = abort_txn &
                     ((bit_cnt_reg != 3'd0) | ((state_reg == ST_DATA) & ~data_seen_reg));

  always_ff @(posedge ILA_clk or negedge rstn) begin
    if (!rstn) begin
      data_seen_reg <= 1'b0;
      abort_cnt_reg <= '0;
      err_flag_reg  <= 1'b0;
    end else begin
      if (hdr_done)       data_seen_reg <= 1'b0;
      else if (data_done) data_seen_reg <= 1'b1;
      if (abort_evt) begin
        err_flag_reg <= 1'b1;
        if (abort_cnt_reg != 16'hFFFF) abort_cnt_reg <= abort_cnt_reg + 16'd1;
      end
    end
  end

  assign abort_cnt = abort_cnt_reg;
  assign err_flag  = err_flag_reg;
`endif

endmodule

// File: tb/tb_cc1200_spi_responder.sv
// Directed + randomized bench for cc1200_spi_responder against a register-map model.
module tb_cc1200_spi_responder;

  logic       ILA_clk = 1'b0;
  logic       rstn = 1'b0;
  logic       SCLK = 1'b0;
  logic       CS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic [7:0] status = 8'h00;
  logic [5:0] dbg_addr = 6'd0;
  logic       MISO, MISO_oe, wr_valid;
  logic [5:0] wr_addr;
  logic [7:0] wr_data, dbg_data;
`ifdef CC1200_SPI_RESP_ERR_EN
  logic [15:0] abort_cnt;
  logic        err_flag;
`endif

  cc1200_spi_responder #(.ADDR_W(6), .SYNC_STAGES(2), .RST_VAL(8'h00)) dut (
    .ILA_clk(ILA_clk), .rstn(rstn), .SCLK(SCLK), .CS_n(CS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .status(status),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef CC1200_SPI_RESP_ERR_EN
    , .abort_cnt(abort_cnt), .err_flag(err_flag)
`endif
  );

  always #5 ILA_clk = ~ILA_clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  model_rf [64];
  logic [13:0] wr_q [$];
  logic [7:0]  tx_q [$];
  logic [7:0]  miso_q [$];
  logic        oe_mid;

  always @(negedge ILA_clk) if (wr_valid) wr_q.push_back({wr_addr, wr_data});

  initial begin
    #900000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge ILA_clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mode 0 master: MISO sampled just before each rising edge.
  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = b[i];
      tick(6);
      rx[i] = MISO;
      SCLK = 1'b1;
      tick(6);
      SCLK = 1'b0;
    end
  endtask

  task automatic txn(input logic [7:0] hdr, input int n);
    logic [7:0] rx;
    miso_q.delete();
    CS_n = 1'b0;
    tick(8);
    oe_mid = MISO_oe;
    spi_bits(hdr, 8, rx);
    miso_q.push_back(rx);
    for (int k = 0; k < n; k++) begin
      spi_bits(tx_q[k], 8, rx);
      miso_q.push_back(rx);
    end
    tick(6);
    CS_n = 1'b1;
    tick(8);
  endtask

  task automatic dbg_sweep(input string tag);
    for (int i = 0; i < 64; i++) begin
      dbg_addr = 6'(i);
      #1;
      check(tag, {8'h00, dbg_data}, {8'h00, model_rf[i]});
    end
  endtask

  // Expected results come from the access rules: status first, then bytes at addr, addr+1, ... mod 64.
  task automatic run_and_check(input logic [7:0] hdr, input int n);
    int a, ad;
    logic rd, burst;
    a = int'(hdr[5:0]);
    rd = hdr[7];
    burst = hdr[6];
    wr_q.delete();
    txn(hdr, n);
    check("oe_during", {15'd0, oe_mid}, 16'd1);
    check("status_byte", {8'h00, miso_q[0]}, {8'h00, status});
    for (int k = 0; k < n; k++) begin
      ad = burst ? (a + k) % 64 : a;
      if (rd) begin
        check("read_byte", {8'h00, miso_q[k+1]}, {8'h00, model_rf[ad]});
      end else begin
        model_rf[ad] = tx_q[k];
        if (k < wr_q.size()) check("wr_report", {2'b00, wr_q[k]}, {2'b00, 6'(ad), tx_q[k]});
      end
    end
    check("wr_count", 16'(wr_q.size()), rd ? 16'd0 : 16'(n));
    check("oe_after", {15'd0, MISO_oe}, 16'd0);
    $display("txn hdr=%02h n=%0d status=%02h miso0=%02h writes=%0d", hdr, n, status, miso_q[0], wr_q.size());
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] hdr;
    for (int i = 0; i < 64; i++) model_rf[i] = 8'h00;

    tick(4);
    rstn = 1'b1;
    tick(4);
    check("rst_miso", {15'd0, MISO}, 16'd0);
    check("rst_oe", {15'd0, MISO_oe}, 16'd0);
    check("rst_wr_valid", {15'd0, wr_valid}, 16'd0);
    check("rst_wr_addr", {10'd0, wr_addr}, 16'd0);
    check("rst_wr_data", {8'd0, wr_data}, 16'd0);
    dbg_sweep("rst_rf");

    // Single write then single read with status.
    tx_q = {8'hA5};
    run_and_check(8'h05, 1);
    dbg_addr = 6'd5;
    #1;
    check("dbg_5", {8'h00, dbg_data}, 16'h00A5);
    status = 8'h3C;
    tx_q = {8'h00};
    run_and_check(8'h85, 1);

    // Burst write wrapping 62 -> 63 -> 0, then burst read back.
    tx_q = {8'h11, 8'h22, 8'h33};
    run_and_check(8'h7E, 3);
    status = 8'hC3;
    tx_q = {8'h00, 8'h00, 8'h00};
    run_and_check(8'hFE, 3);

    // Abort after 5 data bits: no write.
    wr_q.delete();
    CS_n = 1'b0;
    tick(8);
    spi_bits(8'h05, 8, rx);
    spi_bits(8'hFF, 5, rx);
    tick(6);
    CS_n = 1'b1;
    tick(8);
    check("abort_wr_count", 16'(wr_q.size()), 16'd0);
    dbg_addr = 6'd5;
    #1;
    check("abort_rf5", {8'h00, dbg_data}, 16'h00A5);
    check("abort_oe", {15'd0, MISO_oe}, 16'd0);
`ifdef CC1200_SPI_RESP_ERR_EN
    check("abort_cnt_1", abort_cnt, 16'd1);
    check("err_flag_1", {15'd0, err_flag}, 16'd1);
`endif
    $display("txn abort hdr=05 bits=5 writes=%0d", wr_q.size());

    // CS_n rising together with the 8th rise of a data byte: no write.
    wr_q.delete();
    CS_n = 1'b0;
    tick(8);
    spi_bits(8'h07, 8, rx);
    spi_bits(8'h5B, 7, rx);
    MOSI = 1'b1;
    tick(6);
    SCLK = 1'b1;
    CS_n = 1'b1;
    tick(6);
    SCLK = 1'b0;
    tick(8);
    check("csrise_wr_count", 16'(wr_q.size()), 16'd0);
    dbg_addr = 6'd7;
    #1;
    check("csrise_rf7", {8'h00, dbg_data}, {8'h00, model_rf[7]});
`ifdef CC1200_SPI_RESP_ERR_EN
    check("abort_cnt_2", abort_cnt, 16'd2);
`endif
    $display("txn cs_rise_on_8th hdr=07 writes=%0d", wr_q.size());

    // SCLK activity with CS_n high is ignored.
    wr_q.delete();
    for (int i = 0; i < 24; i++) begin
      MOSI = 1'($urandom);
      tick(6);
      SCLK = ~SCLK;
    end
    SCLK = 1'b0;
    tick(8);
    check("idle_sclk_wr", 16'(wr_q.size()), 16'd0);
    check("idle_sclk_oe", {15'd0, MISO_oe}, 16'd0);
    $display("txn idle_sclk toggles=24 writes=%0d", wr_q.size());

    // Randomized mix of single/burst reads and writes.
    for (int t = 0; t < 24; t++) begin
      int n;
      status = 8'($urandom);
      hdr = 8'($urandom);
      if (t % 4 == 0) hdr[5:0] = 6'($urandom_range(60, 63));
      n = hdr[6] ? $urandom_range(1, 4) : 1;
      tx_q.delete();
      for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
      run_and_check(hdr, n);
    end
    dbg_sweep("rand_rf");

    // Reset during the second byte of a burst write.
    CS_n = 1'b0;
    tick(8);
    spi_bits(8'h4A, 8, rx);
    spi_bits(8'hDE, 8, rx);
    spi_bits(8'hAD, 4, rx);
    rstn = 1'b0;
    tick(2);
    check("midrst_oe", {15'd0, MISO_oe}, 16'd0);
    check("midrst_miso", {15'd0, MISO}, 16'd0);
    SCLK = 1'b0;
    CS_n = 1'b1;
    tick(4);
    rstn = 1'b1;
    tick(8);
    for (int i = 0; i < 64; i++) model_rf[i] = 8'h00;
    dbg_sweep("midrst_rf");
`ifdef CC1200_SPI_RESP_ERR_EN
    check("midrst_abort_cnt", abort_cnt, 16'd0);
    check("midrst_err_flag", {15'd0, err_flag}, 16'd0);
`endif
    $display("txn reset_mid_burst hdr=4A");
    status = 8'h5A;
    tx_q = {8'hFF};
    run_and_check(8'h85, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
